// File: rtl/alu_dispatch.sv
// alu_dispatch: ALU issue stage with busy-bit scoreboard and registered operand output.
// Define ALU_DISPATCH_BYPASS_EN to forward writeback data into the issuing instruction.
module alu_dispatch #(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  ope,
  output logic [31:0] ds,
  output logic [31:0] dt,
  output logic [4:0]  out_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        illegal
);
`ifdef ALU_DISPATCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [5:0] op;
  logic [4:0] rd, rs, rt;
  logic [15:0] imm;
  logic reg_form, imm_form, legal, hazard, accept, dispatch;
  logic zero_rs, zero_rt, fwd_rs, fwd_rt;
  logic [31:0] src_s, src_t, imm_t;
  logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff, wb_mask;
  logic out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic [2:0] ope_q, ope_d;
  logic [31:0] ds_q, ds_d, dt_q, dt_d;
  logic [4:0] rd_q, rd_d;
  assign {op, rd, rs, rt} = in_instr[31:11];
  assign imm = in_instr[15:0];
  assign rs_addr = rs;
  assign rt_addr = rt;
  assign reg_form = op >= 6'h01 && op <= 6'h05;
  assign imm_form = op >= 6'h09 && op <= 6'h0D;
  assign legal = reg_form || imm_form || op == 6'h06;
  // A register retiring this cycle is not a hazard when its value can be forwarded.
  always_comb begin
    wb_mask = '0;
    wb_mask[wb_rd] = BYPASS && wb_valid;
  end
  assign busy_eff = busy_q & ~wb_mask;
  assign hazard = legal && (busy_eff[rs] || (reg_form && busy_eff[rt]) || busy_eff[rd]);
  assign in_ready = rstn && !hazard && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign dispatch = accept && legal;
  assign zero_rs = ZERO_REG != 0 && rs == 5'd0;
  assign zero_rt = ZERO_REG != 0 && rt == 5'd0;
  assign fwd_rs = BYPASS && wb_valid && wb_rd == rs && rs != 5'd0;
  assign fwd_rt = BYPASS && wb_valid && wb_rd == rt && rt != 5'd0;
  assign src_s = zero_rs ? 32'd0 : fwd_rs ? wb_data : rs_data;
  assign src_t = zero_rt ? 32'd0 : fwd_rt ? wb_data : rt_data;
  // Opcode low bits already equal the ALU op for every legal encoding.
  assign imm_t = op == 6'h06 ? {16'd0, imm} :
                 (op == 6'h09 || op == 6'h0A) ? {{16{imm[15]}}, imm} : {27'd0, imm[4:0]};
  always_comb begin
    out_valid_d = dispatch ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    ope_d = dispatch ? op[2:0] : ope_q;
    ds_d = dispatch ? src_s : ds_q;
    dt_d = dispatch ? (reg_form ? src_t : imm_t) : dt_q;
    rd_d = dispatch ? rd : rd_q;
    illegal_d = accept && !legal;
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (dispatch && !(ZERO_REG != 0 && rd == 5'd0)) busy_d[rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      ope_q <= 3'd0;
      ds_q <= 32'd0;
      dt_q <= 32'd0;
      rd_q <= 5'd0;
      illegal_q <= 1'b0;
      busy_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ope_q <= ope_d;
      ds_q <= ds_d;
      dt_q <= dt_d;
      rd_q <= rd_d;
      illegal_q <= illegal_d;
      busy_q <= busy_d;
    end
  end
  assign out_valid = out_valid_q;
  assign ope = ope_q;
  assign ds = ds_q;
  assign dt = dt_q;
  assign out_rd = rd_q;
  assign illegal = illegal_q;
endmodule
